// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    // Encoding matches the div_mult_sel output seen by the HI/LO source mux.
    typedef enum logic {
        OP_DIV  = 1'b0,
        OP_MULT = 1'b1
    } muldiv_op_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath with sign correction.
// One 2*WIDTH register serves both ops: {product} or {remainder, quotient}.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  muldiv_op_t       opSel,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   magB;
    logic               signA;
    logic               signB;

    logic [WIDTH-1:0]   magAIn;
    logic [WIDTH-1:0]   magBIn;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH+1:0]   divDiff;
    logic [2*WIDTH-1:0] accNext;
    logic [2*WIDTH-1:0] prodFixed;
    logic [WIDTH-1:0]   quoFixed;
    logic [WIDTH-1:0]   remFixed;

    // The most negative operand maps to itself, which read unsigned is 2^(WIDTH-1).
    assign magAIn = opA[WIDTH-1] ? -opA : opA;
    assign magBIn = opB[WIDTH-1] ? -opB : opB;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        accNext = acc;
        mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magB} : '0);
        divDiff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, magB};
        if (opSel == OP_MULT) begin
            accNext = {mulSum, acc[WIDTH-1:1]};
        end else if (divDiff[WIDTH+1]) begin
            accNext = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            accNext = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    assign prodFixed = (signA ^ signB) ? -acc : acc;
    assign quoFixed  = (signA ^ signB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign remFixed  = signA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            magB  <= '0;
            signA <= 1'b0;
            signB <= 1'b0;
            hiOut <= '0;
            loOut <= '0;
        end else if (load) begin
            acc   <= {{WIDTH{1'b0}}, magAIn};
            magB  <= magBIn;
            signA <= opA[WIDTH-1];
            signB <= opB[WIDTH-1];
        end else if (step) begin
            acc <= accNext;
        end else if (fix) begin
            if (opSel == OP_MULT) begin
                hiOut <= prodFixed[2*WIDTH-1:WIDTH];
                loOut <= prodFixed[WIDTH-1:0];
            end else begin
                hiOut <= remFixed;
                loOut <= quoFixed;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencing FSM for the iterative signed multiply/divide engine feeding HI/LO.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             hi_we,
    output logic             lo_we,
    output logic             div_mult_sel,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t    state;
    muldiv_op_t       opSel;
    logic [CNT_W-1:0] count;
    logic             divByZero;
    logic             loadStrobe;

    assign divByZero    = (op_b == '0);
    assign loadStrobe   = (state == IDLE) && (start_mult || (start_div && !divByZero));
    assign div_mult_sel = opSel;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            opSel    <= OP_DIV;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_we    <= 1'b0;
            lo_we    <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_we    <= 1'b0;
            lo_we    <= 1'b0;
            case (state)
                IDLE: begin
                    // Multiply has priority when both starts arrive together.
                    if (start_mult) begin
                        opSel <= OP_MULT;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (start_div) begin
                        opSel <= OP_DIV;
                        if (divByZero) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            count <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    hi_we <= 1'b1;
                    lo_we <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) datapath (
        .clk   (clk),
        .reset (reset),
        .load  (loadStrobe),
        .step  (state == RUN),
        .fix   (state == FIX),
        .opSel (opSel),
        .opA   (op_a),
        .opB   (op_b),
        .hiOut (hi_out),
        .loOut (lo_out)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vectors, corner sequences, randomized ops.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        hi_we;
    logic        lo_we;
    logic        div_mult_sel;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int tests  = 0;
    int failed = 0;
    logic [31:0] lastHi = '0;
    logic [31:0] lastLo = '0;

    typedef struct {
        string       name;
        bit          m;
        bit          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          intrudeAt;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_mult   (start_mult),
        .start_div    (start_div),
        .op_a         (op_a),
        .op_b         (op_b),
        .busy         (busy),
        .done         (done),
        .div_zero     (div_zero),
        .hi_we        (hi_we),
        .lo_we        (lo_we),
        .div_mult_sel (div_mult_sel),
        .hi_out       (hi_out),
        .lo_out       (lo_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic; remainder follows the dividend, quotient truncates.
    function automatic logic [63:0] refModel(input bit m, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (m) return 64'(sa * sb);
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic runOp(input string name, input bit m, input bit d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo,
                         input int intrudeAt);
        bit isZero;
        bit busyGap;
        int n;
        isZero  = !m && (b == 32'd0);
        busyGap = 1'b0;
        n       = 0;
        @(negedge clk);
        start_mult = m;
        start_div  = d;
        op_a       = a;
        op_b       = b;
        @(posedge clk);
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        while (!done && n < 60) begin
            if (!busy) busyGap = 1'b1;
            if (n == intrudeAt) begin
                start_div = 1'b1;
                op_a      = 32'd9;
                op_b      = 32'd0;
            end
            @(posedge clk);
            @(negedge clk);
            start_div = 1'b0;
            n++;
        end
        check({name, " latency"}, 64'(n), isZero ? 64'd0 : 64'd33);
        check({name, " busy_run"}, 64'(busyGap), 64'd0);
        check({name, " done_flags"}, {58'd0, done, busy, div_zero, hi_we, lo_we, div_mult_sel},
              {58'd0, 1'b1, 1'b0, isZero, !isZero, !isZero, m});
        check({name, " result"}, {hi_out, lo_out}, {expHi, expLo});
        @(negedge clk);
        check({name, " pulse_end"}, {61'd0, done, hi_we, lo_we}, 64'd0);
        if (!isZero) begin
            lastHi = expHi;
            lastLo = expLo;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"mult_7xm3",      1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, -1};
        vecs[1] = '{"div_m7d2",       1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, -1};
        vecs[2] = '{"div_100d7",      1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       -1};
        vecs[3] = '{"div_min_dm1",    1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, -1};
        vecs[4] = '{"mult_min_min",   1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        -1};
        vecs[5] = '{"mult_intrude",   1'b1, 1'b0, 32'd12345,    32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFEDEAA, 10};
        vecs[6] = '{"both_starts",    1'b1, 1'b1, 32'd5,        32'd6,        32'd0,        32'd30,       -1};
        vecs[7] = '{"div_m100d7",     1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, -1};

        reset      = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        #12;
        check("reset_flags", {58'd0, busy, done, div_zero, hi_we, lo_we, div_mult_sel}, 64'd0);
        check("reset_result", {hi_out, lo_out}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i].name, vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
                  vecs[i].expHi, vecs[i].expLo, vecs[i].intrudeAt);
        end

        // Divide by zero: one-cycle flag, previous HI/LO retained, never busy.
        runOp("div_5d0", 1'b0, 1'b1, 32'd5, 32'd0, lastHi, lastLo, -1);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start_div = 1'b1;
        op_a      = 32'd1000;
        op_b      = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start_div = 1'b0;
        repeat (14) @(negedge clk);
        check("mid_div_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_flags", {58'd0, busy, done, div_zero, hi_we, lo_we, div_mult_sel}, 64'd0);
        check("async_reset_result", {hi_out, lo_out}, 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        lastHi = '0;
        lastLo = '0;
        runOp("post_reset_3x4", 1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, -1);

        // Randomized ops against the arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] specials [6];
            logic [31:0] a;
            logic [31:0] b;
            logic [63:0] exp;
            bit m;
            bit d;
            specials[0] = 32'd0;
            specials[1] = 32'd1;
            specials[2] = 32'hFFFFFFFF;
            specials[3] = 32'h80000000;
            specials[4] = 32'h7FFFFFFF;
            specials[5] = $urandom;
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            m = 1'($urandom_range(0, 1));
            d = m ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!m && b == 32'd0) exp = {lastHi, lastLo};
            else exp = refModel(m, a, b);
            runOp($sformatf("rand%0d", i), m, d, a, b, exp[63:32], exp[31:0], -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative signed multiply/divide engine with its own sequencing FSM, sitting between the main control unit and the HI/LO register pair of the multicycle CPU. Control issues a one-cycle start pulse with the two register operands. The block runs a fixed-length shift-add multiply or restoring divide, then drives the HI/LO write enables and the div/mult source select for one cycle. Control stalls on `busy` and resumes on `done`; a zero divisor is reported through `div_zero` instead of writing HI/LO.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `start_mult`  in  1  one-cycle pulse; begin signed multiply of `op_a`×`op_b`.
- `start_div`  in  1  one-cycle pulse; begin signed divide `op_a`/`op_b`.
- `op_a`  in  32  rs value; sampled only on an accepted start.
- `op_b`  in  32  rt value; sampled only on an accepted start.
- `busy`  out  1  high in RUN and FIX.
- `done`  out  1  one-cycle pulse in DONE.
- `div_zero`  out  1  high with `done` when a divide had `op_b`==0.
- `hi_we`  out  1  HI register load, high in DONE unless `div_zero`.
- `lo_we`  out  1  LO register load, same condition as `hi_we`.
- `div_mult_sel`  out  1  0 = divide result, 1 = multiply result; holds last accepted op.
- `hi_out`  out  32  result high word (mult product[63:32] / div remainder).
- `lo_out`  out  32  result low word (mult product[31:0] / div quotient).

## Operation
- States: IDLE, RUN, FIX, DONE.
- Starts are accepted only in IDLE; starts in any other state are ignored.
- If both starts arrive together, multiply wins.
- Accepted start (IDLE, edge E0):
  - latch magnitudes |op_a| and |op_b|, the sign bits, and the op type;
  - iteration counter ← 0; go to RUN.
- Divide with `op_b`==0: IDLE → DONE directly. `div_zero`=1, `hi_we`=`lo_we`=0, result registers unchanged.
- RUN, multiply: unsigned shift-add, one partial-product step per cycle on a 64-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle (remainder shift, trial subtract, restore on borrow).
- RUN length: counter increments each cycle; after step 31 (counter==31) go to FIX.
- FIX sign correction, then load hi/lo result registers; go to DONE.
  - Multiply: negate the 64-bit product if sign_a≠sign_b.
  - Divide: quotient negated if sign_a≠sign_b; remainder takes sign_a.
- DONE: `done`=1, write enables asserted as above; next state is IDLE.
- Arithmetic edge cases:
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, no flag.
  - 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
  - Magnitude of 0x80000000 is taken as unsigned 2^31.
- Reset, asynchronous at any time including mid-operation:
  - state ← IDLE;
  - all outputs 0 (`busy`, `done`, `div_zero`, `hi_we`, `lo_we`, `div_mult_sel`, `hi_out`, `lo_out`);
  - counter and internal registers ← 0.

## Timing
- Start sampled at E0.
- `busy` is high from after E0 through E33.
- RUN occupies E1–E32; FIX is evaluated at E33.
- `done`, `hi_we`, `lo_we` are high during the cycle after E33, 33 cycles after the start edge. HI/LO registers load at E34.
- A new start is accepted no earlier than the IDLE cycle after E34.
- Zero-divide: `done`+`div_zero` high in the cycle after E0 (latency 1).
- `hi_out`/`lo_out` are register outputs, stable from DONE until the next successful completion.
- All outputs are registered or decoded from state only; no input-to-output combinational path.

## Structure
- Package `muldiv_pkg`:
  - state enum `muldiv_state_t` {IDLE, RUN, FIX, DONE};
  - `MD_WIDTH`=32, `MD_ITER`=32;
  - op enum {OP_DIV=0, OP_MULT=1}, matching the `div_mult_sel` encoding.
- One natural sub-module, `muldiv_datapath`:
  - holds the accumulator, remainder/quotient shift registers and sign-fix logic;
  - takes load/step/fix strobes from the FSM in `muldiv_sequencer`.

## Test plan
- `start_mult`, 7 × 0xFFFFFFFD (−3) → `done` 33 cycles after start, HI=0xFFFFFFFF, LO=0xFFFFFFEB, `div_mult_sel`=1, `hi_we`=`lo_we`=1 for exactly one cycle.
- `start_div`, 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, `div_mult_sel`=0; also 100/7 → LO=14, HI=2.
- `start_div`, 5 / 0 → `done`=`div_zero`=1 one cycle later, `hi_we`=`lo_we`=0, prior HI/LO unchanged, `busy` never high.
- Boundaries:
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- Protocol:
  - pulse `start_div` at cycle 10 of a running multiply → ignored, multiply result correct;
  - simultaneous `start_mult`+`start_div` → multiply performed.
- Reset:
  - assert `reset` at cycle 15 of a divide → all outputs 0 immediately (asynchronous), state IDLE;
  - a new multiply 3×4 then completes with LO=12, HI=0.
